// File: rtl/pca_tpu_pkg.sv
// Shared definitions for the PCA/TPU datapath: default sizes, collector states
// and the row-major flattened-matrix bit-offset helper.
package pca_tpu_pkg;

    localparam int DEF_MATRIX_SIZE = 4;
    localparam int DEF_DATA_WIDTH  = 8;
    localparam int SKEW_CYCLES     = 2 * DEF_MATRIX_SIZE - 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } collect_state_t;

    // Element (r,c) of an n x n matrix; row 0, col 0 lands in the MSBs.
    function automatic int flat_offset(input int r, input int c, input int n, input int dw);
        return (n * n - 1 - (r * n + c)) * dw;
    endfunction

endpackage

// File: rtl/deskew_lane_capture.sv
// One output lane's register column: stores row (t - LANE) of column LANE
// whenever the skew cycle falls inside this lane's window.
module deskew_lane_capture
    import pca_tpu_pkg::*;
#(
    parameter int MATRIX_SIZE = DEF_MATRIX_SIZE,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int LANE        = 0,
    parameter int CNT_W       = 3
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  capture,
    input  logic [CNT_W-1:0]                      t,
    input  logic [DATA_WIDTH-1:0]                 lane_data,
    output logic [MATRIX_SIZE-1:0][DATA_WIDTH-1:0] col_next
);

    logic [MATRIX_SIZE-1:0][DATA_WIDTH-1:0] col_q;

    // Exposing the next-state view lets the top publish the final row on the
    // same edge that captures it.
    always_comb begin
        col_next = col_q;
        for (int r = 0; r < MATRIX_SIZE; r++) begin
            if (capture && (t == CNT_W'(LANE + r)))
                col_next[r] = lane_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            col_q <= '0;
        else
            col_q <= col_next;
    end

endmodule

// File: rtl/result_deskew_collector.sv
// Receive end of the systolic array: undoes the diagonal skew of the TPU output
// lanes and publishes the assembled N x N result as one flattened word.
module result_deskew_collector
    import pca_tpu_pkg::*;
#(
    parameter int MATRIX_SIZE = DEF_MATRIX_SIZE,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    input  logic [DATA_WIDTH-1:0]                    TPU_outarray [MATRIX_SIZE],
    output logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0] flattened_result_output,
    output logic                                     busy,
    output logic                                     done_collect,
    output logic                                     result_valid
);

    localparam int SKEW  = 2 * MATRIX_SIZE - 1;
    localparam int LAST  = SKEW - 1;
    localparam int CNT_W = (SKEW > 1) ? $clog2(SKEW) : 1;

    collect_state_t   state;
    logic [CNT_W-1:0] cnt;
    logic             cap_en;
    logic [CNT_W-1:0] cap_t;
    logic             launch;

    logic [MATRIX_SIZE-1:0][MATRIX_SIZE-1:0][DATA_WIDTH-1:0] cols_next;
    logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0]           flat_next;

    // A start is honoured only from IDLE or DONE; inside COLLECT it is ignored.
    assign launch = start && (state != ST_COLLECT);
    assign cap_en = (state == ST_COLLECT) || launch;
    assign cap_t  = (state == ST_COLLECT) ? cnt : '0;

    for (genvar j = 0; j < MATRIX_SIZE; j++) begin : g_lane
        deskew_lane_capture #(
            .MATRIX_SIZE (MATRIX_SIZE),
            .DATA_WIDTH  (DATA_WIDTH),
            .LANE        (j),
            .CNT_W       (CNT_W)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .capture   (cap_en),
            .t         (cap_t),
            .lane_data (TPU_outarray[j]),
            .col_next  (cols_next[j])
        );
    end

    always_comb begin
        flat_next = '0;
        for (int r = 0; r < MATRIX_SIZE; r++) begin
            for (int c = 0; c < MATRIX_SIZE; c++) begin
                flat_next[flat_offset(r, c, MATRIX_SIZE, DATA_WIDTH) +: DATA_WIDTH] = cols_next[c][r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                   <= ST_IDLE;
            cnt                     <= '0;
            flattened_result_output <= '0;
            busy                    <= 1'b0;
            done_collect            <= 1'b0;
            result_valid            <= 1'b0;
        end else begin
            done_collect <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (launch) begin
                        cnt          <= CNT_W'(1);
                        busy         <= 1'b1;
                        result_valid <= 1'b0;
                        state        <= ST_COLLECT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_COLLECT: begin
                    if (cnt == CNT_W'(LAST)) begin
                        flattened_result_output <= flat_next;
                        cnt                     <= '0;
                        busy                    <= 1'b0;
                        done_collect            <= 1'b1;
                        result_valid            <= 1'b1;
                        state                   <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
